div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Issue/collect stage directly upstream of the iterative divider.
- Accepts a DIVU/REMU/DIVS/REMS request from the CPU execute stage over a valid/ready handshake and launches the divider with a single-cycle go pulse.
- Waits for the divider's available, captures the result and flags, and holds them on a valid/ready response port until the writeback stage takes them.
- Short-circuits divide-by-zero without starting the divider.

Parameters:
WIDTH, 32, operand/result width
DBZ_QUOTIENT, all ones, quotient returned for divide-by-zero
GUARD, 1, cycles after go during which div_available is ignored

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_op  in  2  00 DIVU, 01 REMU, 10 DIVS, 11 REMS
req_a  in  WIDTH  dividend
req_b  in  WIDTH  divisor
rsp_valid  out  1  result present
rsp_ready  in  1  consumer takes result
rsp_data  out  WIDTH  quotient or remainder
rsp_zero  out  1  rsp_data == 0
rsp_neg  out  1  rsp_data[WIDTH-1]
rsp_dbz  out  1  result came from the divide-by-zero path
rsp_cached  out  1  result came from the cache (0 without macro)
busy  out  1  state != IDLE
div_a, div_b  out  WIDTH  divider operands (registered, stable from LAUNCH through WAIT)
div_go  out  1  one-cycle start pulse
div_divs  out  1  req_op[1]
div_remainder  out  1  req_op[0]
div_c  in  WIDTH  divider result
div_is_zero, div_is_negative  in  1  divider flags
div_available  in  1  divider result valid

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rsp_valid, rsp_dbz, rsp_cached, div_go=0; rsp_data, div_a, div_b=0; rsp_zero=1; rsp_neg=0; cache invalid.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: req_ready=1. Accept on req_valid&req_ready; latch a, b, op.
  - If req_b==0, go to RESP next cycle. Result: DBZ_QUOTIENT for div ops, req_a for rem ops (signed and unsigned alike). rsp_dbz=1; zero/neg computed locally.
  - Otherwise go to LAUNCH.
- LAUNCH: div_go=1 for exactly one cycle; then WAIT with guard counter=GUARD.
- WAIT: counter decrements to 0; div_available is ignored while counter!=0. When counter==0 and div_available=1, capture div_c, div_is_zero, div_is_negative into rsp regs; go to RESP.
  - Latency: accept to rsp_valid = divider latency + GUARD + 2 cycles.
  - Divide-by-zero path latency: 1 cycle.
- RESP: rsp_valid=1; outputs held stable until rsp_ready=1. Handshake cycle returns to IDLE; req_ready is 0 during that cycle (no same-cycle back-to-back accept).
- Only one operation in flight; req_ready=0 in LAUNCH/WAIT/RESP.
- Signed overflow (MIN / -1) is passed to the divider unchanged; the sequencer does not special-case it.
- Reset mid-operation: returns to IDLE immediately, and any divider result still in flight is discarded. The divider shares the reset, so nothing further is required.
- rsp_data and flags change only on entry to RESP.

Optional Feature:
- Macro: DIVSEQ_RESULT_CACHE_EN.
- With the macro: a one-entry cache of {a, b, op, data, zero, neg}, valid bit cleared by reset. It is written on every divider completion but not on the dbz path. On accept, an exact {a, b, op} hit goes to RESP next cycle with the cached values, rsp_cached=1, and no div_go.
- Without the macro: no storage; rsp_cached tied 0; every nonzero-divisor request launches the divider.

Decomposition:
- Package divseq_pkg: op encodings (OP_DIVU..OP_REMS) and the state enum/localparams IDLE/LAUNCH/WAIT/RESP.
- Natural sub-module: divseq_cache (compare + storage), instantiated only under DIVSEQ_RESULT_CACHE_EN.
- The FSM stays in div_sequencer.

Test Plan:
- DIVU a=100, b=7 against the real divider -> one div_go pulse; rsp_data=14, zero=0, neg=0, dbz=0.
- REMS a=-7 (FFFFFFF9), b=2 -> rsp_data=FFFFFFFF, neg=1; DIVS same operands -> FFFFFFFD.
- DIVU a=5, b=0 -> rsp_valid one cycle after accept, data=FFFFFFFF, dbz=1, div_go never asserted; REMU a=5, b=0 -> data=5.
- Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> outputs stable, req_ready=0; ready pulse -> IDLE next cycle.
- Reset (reset=0) asserted during WAIT -> outputs at reset values immediately; a new DIVU 9/3 afterwards yields 3.
- With DIVSEQ_RESULT_CACHE_EN: repeat DIVU 100/7 -> rsp_cached=1, 1-cycle latency, no div_go; then REMU 100/7 -> miss, divider launched, data=2.

Source files
------------

// File: rtl/divseq_pkg.sv
// ============================================================================
// Module   : divseq_pkg
// Brief    : Shared opcode encodings and FSM state type for div_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package divseq_pkg;

    localparam logic [1:0] OP_DIVU = 2'b00;
    localparam logic [1:0] OP_REMU = 2'b01;
    localparam logic [1:0] OP_DIVS = 2'b10;
    localparam logic [1:0] OP_REMS = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/divseq_cache.sv
// ============================================================================
// Module   : divseq_cache
// Brief    : One-entry cache of the last divider result, keyed by {a, b, op}.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module divseq_cache #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_lookup_a,
    input  logic [WIDTH-1:0] i_lookup_b,
    input  logic [1:0]       i_lookup_op,
    output logic             o_hit,
    output logic [WIDTH-1:0] o_hit_data,
    output logic             o_hit_zero,
    output logic             o_hit_neg,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_a,
    input  logic [WIDTH-1:0] i_wr_b,
    input  logic [1:0]       i_wr_op,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_wr_zero,
    input  logic             i_wr_neg
);

    logic             r_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_neg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 2'b00;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_a     <= i_wr_a;
            r_b     <= i_wr_b;
            r_op    <= i_wr_op;
            r_data  <= i_wr_data;
            r_zero  <= i_wr_zero;
            r_neg   <= i_wr_neg;
        end
    end

    assign o_hit      = r_valid && (r_a == i_lookup_a) && (r_b == i_lookup_b)
                        && (r_op == i_lookup_op);
    assign o_hit_data = r_data;
    assign o_hit_zero = r_zero;
    assign o_hit_neg  = r_neg;

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module   : div_sequencer
// Brief    : Issue/collect stage for the iterative divider; short-circuits
//            divide-by-zero. DIVSEQ_RESULT_CACHE_EN adds a one-entry cache.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sequencer
    import divseq_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] DBZ_QUOTIENT = '1,
    parameter int               GUARD        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_dbz,
    output logic             rsp_cached,
    output logic             busy,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_go,
    output logic             div_divs,
    output logic             div_remainder,
    input  logic [WIDTH-1:0] div_c,
    input  logic             div_is_zero,
    input  logic             div_is_negative,
    input  logic             div_available
);

    localparam int          c_GW    = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [c_GW-1:0] c_GUARD = c_GW'(GUARD);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [c_GW-1:0]  r_guard;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_zero;
    logic             r_rsp_neg;
    logic             r_rsp_dbz;
    logic             r_rsp_cached;

    logic             w_accept;
    logic             w_dbz;
    logic             w_done;
    logic [WIDTH-1:0] w_dbz_data;
    logic             w_hit;
    logic [WIDTH-1:0] w_hit_data;
    logic             w_hit_zero;
    logic             w_hit_neg;

    assign w_accept   = (r_state == IDLE) && req_valid;
    assign w_dbz      = (req_b == '0);
    assign w_done     = (r_state == WAIT) && (r_guard == '0) && div_available;
    // Remainder ops return the dividend on divide-by-zero, signed or not.
    assign w_dbz_data = req_op[0] ? req_a : DBZ_QUOTIENT;

`ifdef DIVSEQ_RESULT_CACHE_EN
    divseq_cache #(
        .WIDTH (WIDTH)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .i_lookup_a  (req_a),
        .i_lookup_b  (req_b),
        .i_lookup_op (req_op),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data),
        .o_hit_zero  (w_hit_zero),
        .o_hit_neg   (w_hit_neg),
        .i_wr_en     (w_done),
        .i_wr_a      (r_a),
        .i_wr_b      (r_b),
        .i_wr_op     (r_op),
        .i_wr_data   (div_c),
        .i_wr_zero   (div_is_zero),
        .i_wr_neg    (div_is_negative)
    );
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
    assign w_hit_zero = 1'b0;
    assign w_hit_neg  = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = (w_dbz || w_hit) ? RESP : LAUNCH;
                end
            end
            LAUNCH:  w_next_state = WAIT;
            WAIT:    if (w_done) w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Response registers are only ever loaded on the cycle that enters RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= OP_DIVU;
            r_guard      <= '0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b1;
            r_rsp_neg    <= 1'b0;
            r_rsp_dbz    <= 1'b0;
            r_rsp_cached <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= req_a;
                r_b  <= req_b;
                r_op <= req_op;
                if (w_dbz) begin
                    r_rsp_data   <= w_dbz_data;
                    r_rsp_zero   <= (w_dbz_data == '0);
                    r_rsp_neg    <= w_dbz_data[WIDTH-1];
                    r_rsp_dbz    <= 1'b1;
                    r_rsp_cached <= 1'b0;
                end else if (w_hit) begin
                    r_rsp_data   <= w_hit_data;
                    r_rsp_zero   <= w_hit_zero;
                    r_rsp_neg    <= w_hit_neg;
                    r_rsp_dbz    <= 1'b0;
                    r_rsp_cached <= 1'b1;
                end
            end
            if (r_state == LAUNCH) begin
                r_guard <= c_GUARD;
            end else if ((r_state == WAIT) && (r_guard != '0)) begin
                r_guard <= r_guard - c_GW'(1);
            end
            if (w_done) begin
                r_rsp_data   <= div_c;
                r_rsp_zero   <= div_is_zero;
                r_rsp_neg    <= div_is_negative;
                r_rsp_dbz    <= 1'b0;
                r_rsp_cached <= 1'b0;
            end
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign rsp_valid     = (r_state == RESP);
    assign busy          = (r_state != IDLE);
    assign div_go        = (r_state == LAUNCH);
    assign div_a         = r_a;
    assign div_b         = r_b;
    assign div_divs      = r_op[1];
    assign div_remainder = r_op[0];
    assign rsp_data      = r_rsp_data;
    assign rsp_zero      = r_rsp_zero;
    assign rsp_neg       = r_rsp_neg;
    assign rsp_dbz       = r_rsp_dbz;
    assign rsp_cached    = r_rsp_cached;

endmodule

`default_nettype wire
